axis_ramped_volume: RTL
=======================

Name: axis_ramped_volume

Overview:
- AXI-Stream audio gain stage for the I2S2 Line In -> Line Out path.
- Next generation of the switch-driven volume controller. It is generalised to NUM_CHANNELS interleaved channels per frame.
- Adds switch synchronisation, per-frame gain ramping (no zipper noise) and a stallable 2-stage pipeline.
- Sits between the rx master and tx slave of axis_i2s2 on axis_clk.

Parameters:
- DATA_WIDTH, 24, signed sample width in bits.
- SWITCH_WIDTH, 4, width of the sw gain-select input.
- NUM_CHANNELS, 2, beats per frame. The last beat of a frame carries last.
- CH_W, $clog2(NUM_CHANNELS) (minimum 1), width of the channel index output.

Ports:
- axis_clk  in  1  sole clock.
- axis_resetn  in  1  asynchronous, active-low reset.
- sw  in  SWITCH_WIDTH  asynchronous gain select (board switches).
- s_axis_data  in  DATA_WIDTH  input sample, two's complement.
- s_axis_valid  in  1  input beat valid.
- s_axis_ready  out  1  block accepts a beat.
- s_axis_last  in  1  final beat of frame.
- m_axis_data  out  DATA_WIDTH  scaled sample.
- m_axis_valid  out  1  output beat valid.
- m_axis_ready  in  1  downstream accepts.
- m_axis_last  out  1  passthrough of s_axis_last.
- m_axis_chan  out  CH_W  channel index of the output beat.
- gain  out  SWITCH_WIDTH+2  current applied gain G, for debug and LEDs.

Behaviour:
- Reset is asynchronous and active-low. While axis_resetn=0:
  - all pipeline valids=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, m_axis_chan=0;
  - G=0, sync flops=0, channel counter=0;
  - s_axis_ready=0 during reset, and 1 from the first clock after release.
- sw passes through a 2-flop synchroniser to sw_s. Target T = (sw_s all ones) ? 2^SWITCH_WIDTH : sw_s, giving unity at full scale.
- Ramp: on each accepted input beat with s_axis_last=1, G steps one toward T (G+1 if G<T, G-1 if G>T, hold if equal).
  - G never changes mid-frame.
  - After reset G=0, so the output fades in over T frames.
  - A sw change mid-ramp retargets at the next frame boundary.
- Input acceptance: an accepted beat is s_axis_valid & s_axis_ready. The beat captures data, last, the channel counter value and the current G into stage 1.
- Channel counter:
  - increments per accepted beat;
  - wraps to 0 after NUM_CHANNELS-1;
  - is forced to 0 after any beat with last=1 (resynchronises on short or long frames).
- Stage 2: product = signed(data) * unsigned(G); result = product >>> SWITCH_WIDTH (arithmetic), truncated to DATA_WIDTH.
  - Overflow is impossible because G <= 2^SWITCH_WIDTH.
  - G=0 yields 0.
- Pipeline and handshake:
  - Each stage advances when its successor is empty or being drained. s_axis_ready = !v1 | advance1, with advance2 = !v2 | m_axis_ready.
  - Latency: an accepted beat appears on m_axis_* exactly 2 cycles later with no stall. Throughput is 1 beat/cycle.
  - A stall holds m_axis_* stable while m_axis_valid=1 & m_axis_ready=0 (AXIS rule).
  - At most 2 beats are buffered. s_axis_ready drops the cycle the pipeline is full and stalled.
  - No beat is dropped or duplicated.
- Simultaneous accept-at-input and drain-at-output in the same cycle is a full-rate pass.
- A last beat accepted in the same cycle G updates is scaled with the old G.
- Reset mid-frame flushes the pipeline. The first beat after release is treated as channel 0.

Optional Feature:
- Macro: AXIS_VOL_BOOST_EN.
- Defined:
  - T = {sw_s,1'b0}, with a maximum of 2*(2^SWITCH_WIDTH-1), about 1.875x.
  - The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before truncation.
- Undefined: unity-max mapping above, with no saturation logic.
- gain port width is unchanged in both cases.

Decomposition:
- Package axis_audio_pkg holds:
  - gain width function gain_w(SWITCH_WIDTH);
  - saturate function (signed, width-generic);
  - UNITY_GAIN constant expression.
- One natural sub-module: gain_ramp. It contains the synchroniser, target mapping and G up/down stepper. Its inputs are sw, frame_done and clock/reset; its output is G.

Test Plan:
- Reset fade-in: SWITCH_WIDTH=4, sw=1111, 2-ch frames, sample 0x400000 every beat -> G=0 first frame (outputs 0), G increments per frame, G=16 after 16 frames, then output 0x400000 steady.
- Scaling and sign: G settled at 8, inputs 0x400000 and 0xC00000 -> outputs 0x200000 and 0xE00000, 2 cycles after accept, m_axis_chan 0,1, last on chan 1.
- Backpressure: continuous valid, m_axis_ready low 5 cycles -> s_axis_ready low after 2 beats buffered, m_axis_* stable, all beats delivered in order, no loss or duplicate.
- Framing: frame of 3 beats with NUM_CHANNELS=2 -> chan 0,1,0, then counter 0 after last; next frame starts at 0.
- Reset mid-frame: assert axis_resetn=0 with 2 beats in flight -> m_axis_valid=0 immediately; after release, G ramps from 0 and the first beat has chan 0.
- Boost (AXIS_VOL_BOOST_EN): sw=1111, G=30, input 0x600000 -> 0x7FFFFF; input 0xA00000 -> 0x800000.

Source files
------------

// File: rtl/axis_ramped_volume_pkg.sv
// Shared helpers for the audio gain path: gain register width, unity gain and signed saturation.
// Optional boost mode (AXIS_VOL_BOOST_EN) uses saturate() to clamp over-range products.
package axis_audio_pkg;

    localparam int SW_DEFAULT = 4;

    function automatic int gain_w(input int sw_w);
        return sw_w + 2;
    endfunction

    function automatic int unity_gain(input int sw_w);
        return 1 << sw_w;
    endfunction

    localparam int UNITY_GAIN = unity_gain(SW_DEFAULT);

    // Clamp x into the signed range of a w-bit number; caller truncates to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/axis_ramped_volume_if.sv
// AXI-Stream beat bundle carrying a sample, frame marker and channel index.
// master drives data/valid/last/chan, slave drives ready.
interface axis_ramped_volume_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CH_W       = 1
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [CH_W-1:0]       chan;

    modport master (output data, valid, last, chan, input ready);
    modport slave  (input data, valid, last, chan, output ready);
endinterface

// File: rtl/axis_ramped_volume_gain_ramp.sv
// Synchronises sw, maps it to a target gain and steps G by one per completed frame.
// AXIS_VOL_BOOST_EN selects the {sw,0} boost mapping instead of the unity-at-full-scale mapping.
module gain_ramp
    import axis_audio_pkg::*;
#(
    parameter int SWITCH_WIDTH = 4
) (
    input  logic                            axis_clk,
    input  logic                            axis_resetn,
    input  logic [SWITCH_WIDTH-1:0]         sw,
    input  logic                            frame_done,
    output logic [gain_w(SWITCH_WIDTH)-1:0] g
);
    localparam int GW = gain_w(SWITCH_WIDTH);

    logic [SWITCH_WIDTH-1:0] sw_m;
    logic [SWITCH_WIDTH-1:0] sw_s;
    logic [GW-1:0]           target;

`ifdef AXIS_VOL_BOOST_EN
    assign target = GW'({sw_s, 1'b0});
`else
    // All-ones maps to exactly 2^SWITCH_WIDTH so full scale is a clean unity gain.
    assign target = (&sw_s) ? GW'(unity_gain(SWITCH_WIDTH)) : GW'(sw_s);
`endif

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            sw_m <= '0;
            sw_s <= '0;
            g    <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            if (frame_done) begin
                if (g < target) begin
                    g <= g + 1'b1;
                end else if (g > target) begin
                    g <= g - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/axis_ramped_volume.sv
// Two-stage stallable AXIS gain stage: capture beat + G, then scale by G / 2^SWITCH_WIDTH.
// Latency 2 cycles, 1 beat/cycle; AXIS_VOL_BOOST_EN adds boost gains with output saturation.
module axis_ramped_volume
    import axis_audio_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int SWITCH_WIDTH = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                            axis_clk,
    input  logic                            axis_resetn,
    input  logic [SWITCH_WIDTH-1:0]         sw,
    axis_ramped_volume_if.slave             s_axis,
    axis_ramped_volume_if.master            m_axis,
    output logic [gain_w(SWITCH_WIDTH)-1:0] gain
);
    localparam int GW = gain_w(SWITCH_WIDTH);
    localparam int PW = DATA_WIDTH + GW + 1;

    logic                  rdy_en;
    logic                  v1;
    logic                  v2;
    logic [DATA_WIDTH-1:0] d1;
    logic                  l1;
    logic [CH_W-1:0]       c1;
    logic [GW-1:0]         g1;
    logic [CH_W-1:0]       cnt;
    logic                  adv2;
    logic                  accept;
    logic                  frame_done;
    logic signed [PW-1:0]  prod;
    logic [DATA_WIDTH-1:0] scaled;

    gain_ramp #(.SWITCH_WIDTH(SWITCH_WIDTH)) u_ramp (
        .axis_clk    (axis_clk),
        .axis_resetn (axis_resetn),
        .sw          (sw),
        .frame_done  (frame_done),
        .g           (gain)
    );

    assign adv2         = !v2 | m_axis.ready;
    assign s_axis.ready = rdy_en & (!v1 | adv2);
    assign accept       = s_axis.valid & s_axis.ready;
    // G steps on the same edge the last beat is captured, so that beat keeps the old G.
    assign frame_done   = accept & s_axis.last;
    assign m_axis.valid = v2;

    assign prod = $signed(d1) * $signed({1'b0, g1});
`ifdef AXIS_VOL_BOOST_EN
    assign scaled = DATA_WIDTH'(saturate(64'(prod >>> SWITCH_WIDTH), DATA_WIDTH));
`else
    assign scaled = DATA_WIDTH'(prod >>> SWITCH_WIDTH);
`endif

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rdy_en      <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            d1          <= '0;
            l1          <= 1'b0;
            c1          <= '0;
            g1          <= '0;
            cnt         <= '0;
            m_axis.data <= '0;
            m_axis.last <= 1'b0;
            m_axis.chan <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (s_axis.ready) begin
                v1 <= s_axis.valid;
            end
            if (accept) begin
                d1 <= s_axis.data;
                l1 <= s_axis.last;
                c1 <= cnt;
                g1 <= gain;
                // A last beat always resynchronises the counter, whatever the frame length.
                if (s_axis.last || cnt == CH_W'(NUM_CHANNELS - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    m_axis.data <= scaled;
                    m_axis.last <= l1;
                    m_axis.chan <= c1;
                end
            end
        end
    end
endmodule
